// File: rtl/ss_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// No logic; latency n/a.
// No flow control; constants only.
package ss_pkg;

    typedef enum logic {
        ST_ON   = 1'b0,
        ST_DEAD = 1'b1
    } ss_state_t;

    // Active-high {g,f,e,d,c,b,a}, index = nibble value
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic int cnt_width(input int slot, input int blank);
        int m;
        m = (slot > blank) ? slot : blank;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ss_hex_decoder.sv
// Nibble to active-high 7-segment glyph (0-9, A b C d E F), forced dark by blank.
// Combinational, zero latency.
// No flow control.
module ss_hex_decoder
    import ss_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? 7'h00 : HEX_GLYPHS[nibble];
    end

endmodule

// File: rtl/ss_scan_ctrl.sv
// Time-multiplexed 7-seg scan with dead time, LZ blanking, frame snapshot; SS_BRIGHTNESS_EN adds PWM dimming.
// Outputs registered: they reflect the state entered on the same clock the tick is taken.
// No backpressure; clk_enable low freezes state and outputs.
module ss_scan_ctrl
    import ss_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int SLOT_TICKS  = 16,
    parameter int BLANK_TICKS = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_enable,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dots,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_blank,
`ifdef SS_BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    output logic [7:0]            ss_value,
    output logic [N_DIGITS-1:0]   ss_select,
    output logic                  frame_start
);

    localparam int   TW  = cnt_width(SLOT_TICKS, BLANK_TICKS);
    localparam int   IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    ss_state_t             state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [TW-1:0]         tcnt, tcnt_nxt;
    logic                  first_tick, advance, wrap, snap;
    logic [4*N_DIGITS-1:0] sh_dig, sh_dig_nxt;
    logic [N_DIGITS-1:0]   sh_dots, sh_dots_nxt, sh_en, sh_en_nxt;
    logic                  sh_lz, sh_lz_nxt;
    logic [N_DIGITS-1:0]   lz_mask, sel_hi;
    logic [7:0]            val_hi;
    logic [6:0]            seg;
    logic [3:0]            cur_nib;
    logic                  pwm_on, lit;
`ifdef SS_BRIGHTNESS_EN
    logic [3:0]            sh_br, sh_br_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ON;
            idx         <= '0;
            tcnt        <= '0;
            first_tick  <= 1'b1;
            sh_dig      <= '0;
            sh_dots     <= '0;
            sh_en       <= '0;
            sh_lz       <= 1'b0;
`ifdef SS_BRIGHTNESS_EN
            sh_br       <= '0;
`endif
            ss_value    <= SEG_OFF ^ {8{POL}};
            ss_select   <= {N_DIGITS{POL}};
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            tcnt        <= tcnt_nxt;
            first_tick  <= first_tick & ~clk_enable;
            sh_dig      <= sh_dig_nxt;
            sh_dots     <= sh_dots_nxt;
            sh_en       <= sh_en_nxt;
            sh_lz       <= sh_lz_nxt;
`ifdef SS_BRIGHTNESS_EN
            sh_br       <= sh_br_nxt;
`endif
            ss_value    <= val_hi ^ {8{POL}};
            ss_select   <= sel_hi ^ {N_DIGITS{POL}};
            frame_start <= snap;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        advance   = 1'b0;
        wrap      = 1'b0;
        if (clk_enable) begin
            case (state)
                ST_ON: begin
                    if (int'(tcnt) == SLOT_TICKS - 1) begin
                        tcnt_nxt = '0;
                        if (BLANK_TICKS > 0) state_nxt = ST_DEAD;
                        else                 advance   = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (int'(tcnt) == BLANK_TICKS - 1) begin
                        tcnt_nxt  = '0;
                        advance   = 1'b1;
                        state_nxt = ST_ON;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
            endcase
        end
        if (advance) begin
            wrap    = (int'(idx) == N_DIGITS - 1);
            idx_nxt = wrap ? '0 : idx + 1'b1;
        end
        // Snapshot lands on the same edge as the wrap so digit 0 already sees the new frame
        snap        = clk_enable && (first_tick || wrap);
        sh_dig_nxt  = snap ? digits   : sh_dig;
        sh_dots_nxt = snap ? dots     : sh_dots;
        sh_en_nxt   = snap ? digit_en : sh_en;
        sh_lz_nxt   = snap ? lz_blank : sh_lz;
`ifdef SS_BRIGHTNESS_EN
        sh_br_nxt   = snap ? brightness : sh_br;
`endif
    end

    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (sh_dig_nxt[4*i +: 4] == 4'h0);
            lz_mask[i] = sh_lz_nxt && all_zero;
        end
    end

    assign cur_nib = sh_dig_nxt[int'(idx_nxt)*4 +: 4];

    ss_hex_decoder u_dec (
        .nibble (cur_nib),
        .blank  (lz_mask[idx_nxt]),
        .seg    (seg)
    );

`ifdef SS_BRIGHTNESS_EN
    assign pwm_on = (int'(tcnt_nxt) * 16) < ((int'(sh_br_nxt) + 1) * SLOT_TICKS);
`else
    assign pwm_on = 1'b1;
`endif

    always_comb begin
        lit    = (state_nxt == ST_ON) && sh_en_nxt[idx_nxt] && pwm_on;
        val_hi = SEG_OFF;
        sel_hi = '0;
        if (lit) begin
            val_hi          = {sh_dots_nxt[idx_nxt], seg};
            sel_hi[idx_nxt] = 1'b1;
        end
    end

endmodule
